// File: rtl/vram_sched_pkg.sv
// Shared types and sizes for the VRAM write scheduler.
package vram_sched_pkg;
  localparam int VRAM_DEPTH = 20480;
  localparam int VRAM_AW    = 19;
  localparam int PIX_W      = 12;

  typedef enum logic {
    S_ARB   = 1'b0,
    S_CLEAR = 1'b1
  } sched_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester granted most recently loses the next tie.
// Latency: grant is combinational from req/accept; the priority pointer updates on each grant.
// Backpressure: accept=0 withholds both grants.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_last <= 1'b1;
    else if (|gnt)
      rr_last <= gnt[1];
  end
endmodule

// File: rtl/vram_write_sched.sv
// Ping-pong VRAM write port: round-robin sharing, frame-tick bank swap, optional clear sweep.
// Latency: accepted request appears on wr_* one cycle later; bank toggles the cycle after the swap event.
// Backpressure: grants are withheld in the swap-event cycle and for the whole clear sweep.
module vram_write_sched
  import vram_sched_pkg::*;
#(
  parameter int ADDR_W = VRAM_AW,
  parameter int DATA_W = PIX_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              swap_req,
  input  logic              clear_en,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_gnt,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_bank,
  output logic              swap_ack,
  output logic              clearing,
  output logic [15:0]       frame_count
);
  localparam int CNT_W = $clog2(DEPTH);

  sched_state_t      state, state_nxt;
  logic              swap_pending;
  logic              swap_evt;
  logic              accept;
  logic              clear_last;
  logic [1:0]        gnt;
  logic [CNT_W-1:0]  clear_cnt;
  logic [DATA_W-1:0] clear_color_q;

  assign swap_evt = frame_tick & (swap_pending | swap_req) & (state == S_ARB);
  assign clearing = (state == S_CLEAR);
  assign r0_gnt   = gnt[0];
  assign r1_gnt   = gnt[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({r1_req, r0_req}),
    .accept (accept),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_ARB;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    clear_last = 1'b0;
    case (state)
      S_ARB: begin
        // No requester write may straddle the bank toggle.
        accept = ~swap_evt;
        if (swap_evt && clear_en)
          state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clear_last = (clear_cnt == CNT_W'(DEPTH - 1));
        if (clear_last)
          state_nxt = S_ARB;
      end
      default: state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_pending  <= 1'b0;
      swap_ack      <= 1'b0;
      wr_bank       <= 1'b0;
      frame_count   <= 16'd0;
      clear_color_q <= '0;
      clear_cnt     <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      swap_pending <= swap_evt ? 1'b0 : (swap_pending | swap_req);
      swap_ack     <= swap_evt;
      if (swap_evt) begin
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 16'd1;
        if (clear_en)
          clear_color_q <= clear_color;
      end
      if (clearing)
        clear_cnt <= clear_last ? '0 : clear_cnt + 1'b1;

      wr_en <= clearing | (|gnt);
      if (clearing) begin
        wr_addr <= ADDR_W'(clear_cnt);
        wr_data <= clear_color_q;
      end else if (gnt[0]) begin
        wr_addr <= r0_addr;
        wr_data <= r0_data;
      end else if (gnt[1]) begin
        wr_addr <= r1_addr;
        wr_data <= r1_data;
      end
    end
  end
endmodule

// File: tb/tb_vram_write_sched.sv
// Directed bench for vram_write_sched: arbitration, swap timing, clear sweep, reset abort.
module tb_vram_write_sched;
  import vram_sched_pkg::*;

  logic              clk;
  logic              reset;
  logic              frame_tick, swap_req, clear_en;
  logic [PIX_W-1:0]  clear_color;
  logic              r0_req, r1_req, r0_gnt, r1_gnt;
  logic [VRAM_AW-1:0] r0_addr, r1_addr, wr_addr;
  logic [PIX_W-1:0]  r0_data, r1_data, wr_data;
  logic              wr_en, wr_bank, swap_ack, clearing;
  logic [15:0]       frame_count;

  int n_cmp = 0;
  int n_err = 0;

  vram_write_sched dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .swap_req    (swap_req),
    .clear_en    (clear_en),
    .clear_color (clear_color),
    .r0_req      (r0_req),
    .r0_addr     (r0_addr),
    .r0_data     (r0_data),
    .r0_gnt      (r0_gnt),
    .r1_req      (r1_req),
    .r1_addr     (r1_addr),
    .r1_data     (r1_data),
    .r1_gnt      (r1_gnt),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_bank     (wr_bank),
    .swap_ack    (swap_ack),
    .clearing    (clearing),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ncl, nwr, bad, it;
    bit done;

    reset = 1'b0; frame_tick = 0; swap_req = 0; clear_en = 0; clear_color = '0;
    r0_req = 0; r0_addr = '0; r0_data = '0;
    r1_req = 0; r1_addr = '0; r1_data = '0;
    #2;
    chk_eq("rst_wr_en", wr_en, 0);
    chk_eq("rst_wr_addr", wr_addr, 0);
    chk_eq("rst_wr_data", wr_data, 0);
    chk_eq("rst_wr_bank", wr_bank, 0);
    chk_eq("rst_swap_ack", swap_ack, 0);
    chk_eq("rst_clearing", clearing, 0);
    chk_eq("rst_frame_count", frame_count, 0);
    step(); step();
    reset = 1'b1;

    // single requester 0
    r0_req = 1; r0_addr = 5; r0_data = 12'hF00;
    #1;
    chk_eq("r0_only_gnt0", r0_gnt, 1);
    chk_eq("r0_only_gnt1", r1_gnt, 0);
    step(); r0_req = 0;
    chk_eq("r0_wr_en", wr_en, 1);
    chk_eq("r0_wr_addr", wr_addr, 5);
    chk_eq("r0_wr_data", wr_data, 12'hF00);
    chk_eq("r0_wr_bank", wr_bank, 0);
    step();
    chk_eq("idle_wr_en", wr_en, 0);

    // single requester 1, max address passes through
    r1_req = 1; r1_addr = 19'h7FFFF; r1_data = 12'h0A5;
    #1;
    chk_eq("r1_only_gnt1", r1_gnt, 1);
    step(); r1_req = 0;
    chk_eq("r1_wr_addr", wr_addr, 19'h7FFFF);
    chk_eq("r1_wr_data", wr_data, 12'h0A5);

    // both requesting: alternate starting with r0 (r1 was last)
    r0_req = 1; r0_addr = 10; r0_data = 12'h111;
    r1_req = 1; r1_addr = 20; r1_data = 12'h222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_eq($sformatf("rr_gnt0_%0d", i), r0_gnt, (i % 2 == 0) ? 1 : 0);
      chk_eq($sformatf("rr_gnt1_%0d", i), r1_gnt, (i % 2 == 0) ? 0 : 1);
      step();
      chk_eq($sformatf("rr_wr_en_%0d", i), wr_en, 1);
      chk_eq($sformatf("rr_wr_addr_%0d", i), wr_addr, (i % 2 == 0) ? 10 : 20);
    end
    r0_req = 0; r1_req = 0;

    // swap without clear; second swap_req is absorbed
    swap_req = 1; step(); swap_req = 0; step();
    swap_req = 1; step(); swap_req = 0;
    repeat (7) step();
    r0_req = 1; r0_addr = 33; r0_data = 12'h333; frame_tick = 1;
    #1;
    chk_eq("tick_blocks_gnt0", r0_gnt, 0);
    step(); frame_tick = 0;
    chk_eq("swap_wr_en", wr_en, 0);
    chk_eq("swap_bank", wr_bank, 1);
    chk_eq("swap_ack", swap_ack, 1);
    chk_eq("swap_count", frame_count, 1);
    chk_eq("swap_noclear", clearing, 0);
    #1;
    chk_eq("post_swap_gnt0", r0_gnt, 1);
    step(); r0_req = 0;
    chk_eq("swap_ack_pulse", swap_ack, 0);
    chk_eq("post_swap_wr_addr", wr_addr, 33);
    chk_eq("post_swap_bank", wr_bank, 1);

    // tick with nothing pending
    frame_tick = 1; step(); frame_tick = 0;
    chk_eq("idle_tick_ack", swap_ack, 0);
    chk_eq("idle_tick_bank", wr_bank, 1);
    chk_eq("idle_tick_count", frame_count, 1);

    // swap_req and tick together with clear enabled
    clear_en = 1; clear_color = 12'h00F; swap_req = 1; frame_tick = 1;
    r1_req = 1; r1_addr = 44; r1_data = 12'h321;
    #1;
    chk_eq("clr_evt_gnt1", r1_gnt, 0);
    step(); swap_req = 0; frame_tick = 0; clear_en = 0; clear_color = 12'hABC;
    chk_eq("clr_swap_ack", swap_ack, 1);
    chk_eq("clr_swap_bank", wr_bank, 0);
    chk_eq("clr_swap_count", frame_count, 2);
    chk_eq("clr_entered", clearing, 1);
    ncl = 0; nwr = 0; bad = 0; it = 0; done = 0;
    while (!done && it < 21000) begin
      if (clearing) begin
        ncl++;
        if (r0_gnt || r1_gnt) bad++;
        if (wr_bank !== 1'b0) bad++;
      end
      if (wr_en) begin
        if (wr_addr !== VRAM_AW'(nwr) || wr_data !== 12'h00F) bad++;
        nwr++;
      end
      if (!clearing) begin
        done = 1;
      end else begin
        swap_req = (it == 50);
        frame_tick = (it == 60);
        step();
        it++;
      end
    end
    chk_eq("clr_done", done, 1);
    chk_eq("clr_cycles", ncl, 20480);
    chk_eq("clr_writes", nwr, 20480);
    chk_eq("clr_bad_cycles", bad, 0);
    chk_eq("clr_last_addr", wr_addr, 20479);
    chk_eq("clr_end_gnt1", r1_gnt, 1);
    step(); r1_req = 0;
    chk_eq("clr_r1_wr_addr", wr_addr, 44);
    chk_eq("clr_r1_wr_data", wr_data, 12'h321);
    chk_eq("clr_no_toggle", wr_bank, 0);

    // pending swap from the clear is serviced on the next tick
    frame_tick = 1; step(); frame_tick = 0;
    chk_eq("pend_swap_ack", swap_ack, 1);
    chk_eq("pend_swap_bank", wr_bank, 1);
    chk_eq("pend_swap_count", frame_count, 3);

    // reset in the middle of a clear sweep
    clear_en = 1; clear_color = 12'h0F0; swap_req = 1; frame_tick = 1;
    step(); clear_en = 0; swap_req = 0; frame_tick = 0;
    chk_eq("abort_bank", wr_bank, 0);
    chk_eq("abort_count", frame_count, 4);
    it = 0;
    while (!(wr_en && wr_addr == 100) && it < 500) begin
      step();
      it++;
    end
    chk_eq("abort_at_addr", wr_addr, 100);
    chk_eq("abort_at_data", wr_data, 12'h0F0);
    reset = 0;
    #1;
    chk_eq("abort_wr_en", wr_en, 0);
    chk_eq("abort_wr_addr", wr_addr, 0);
    chk_eq("abort_wr_data", wr_data, 0);
    chk_eq("abort_wr_bank", wr_bank, 0);
    chk_eq("abort_clearing", clearing, 0);
    chk_eq("abort_frame_count", frame_count, 0);
    chk_eq("abort_swap_ack", swap_ack, 0);
    step(); reset = 1;
    r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
    #1;
    chk_eq("rearm_gnt0", r0_gnt, 1);
    chk_eq("rearm_gnt1", r1_gnt, 0);
    step(); r0_req = 0; r1_req = 0;
    chk_eq("rearm_wr_addr", wr_addr, 1);
    chk_eq("rearm_clearing", clearing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vram_write_sched.md
Name: vram_write_sched

Overview:
Write-side controller for the ping-pong VRAM pair (two blk_mem_gen_0 banks, 12-bit RGB, 32x640-word depth). It shares the single write port between two requesters (game sprite writer, overlay/bar writer) using round-robin arbitration. It owns the back-bank select and swaps banks only on the frame tick (vpos==480, hpos==0) once a frame is marked complete. It can optionally flood-fill the new back bank with a clear colour after each swap.

Parameters:
ADDR_W, 19, VRAM write address width
DATA_W, 12, pixel width {B,G,R}
DEPTH, 20480, words per bank (32*640); clear sweeps 0..DEPTH-1

Ports:
clk  in  1  pixel clock (clk25M domain)
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
swap_req  in  1  one-cycle pulse: back bank frame complete
clear_en  in  1  fill new back bank after swap
clear_color  in  DATA_W  fill value
r0_req  in  1  requester 0 write request
r0_addr  in  ADDR_W  requester 0 address
r0_data  in  DATA_W  requester 0 data
r0_gnt  out  1  requester 0 accepted this cycle
r1_req / r1_addr / r1_data / r1_gnt  same as r0, requester 1
wr_en  out  1  VRAM write enable (registered)
wr_addr  out  ADDR_W  VRAM write address (registered)
wr_data  out  DATA_W  VRAM write data (registered)
wr_bank  out  1  bank being written (0=vramA); display bank = !wr_bank
swap_ack  out  1  one-cycle pulse on bank toggle
clearing  out  1  clear sweep in progress
frame_count  out  16  completed swaps, wraps at 16'hFFFF->0

Behaviour:
- Reset (async, reset==0): state S_ARB, wr_bank=0, wr_en=0, wr_addr=0, wr_data=0, gnt=0, swap_ack=0, clearing=0, frame_count=0, swap_pending=0, rr_last=1 (r0 wins first tie), clear counter=0.
- States: S_ARB (normal arbitration), S_CLEAR (fill sweep).
- Handshake: requester holds req/addr/data stable until it sees gnt high in the same cycle; gnt is combinational from req, state and rr_last; transfer occurs on req&gnt.
- Arbitration in S_ARB: one request only -> grant it; both -> grant the one not equal to rr_last; rr_last updates on every grant. At most one gnt per cycle.
- Latency: accepted transfer appears on wr_en/wr_addr/wr_data exactly 1 cycle later; wr_en=0 in cycles with no grant.
- swap_pending: set on swap_req, cleared on swap event; swap_req while already pending is absorbed (no double swap).
- Swap event: frame_tick & (swap_pending | swap_req) & state==S_ARB. In that cycle both gnt are forced 0. Next cycle: wr_bank toggles, swap_ack=1 for one cycle, frame_count+1.
- After swap, if clear_en was 1 in the swap-event cycle: enter S_CLEAR the cycle after the swap event. Each cycle emits wr_en=1, wr_addr=counter, wr_data=clear_color (sampled at entry); counter 0..DEPTH-1; clearing=1 throughout; gnt=0. Return to S_ARB after writing DEPTH-1; counter resets to 0.
- frame_tick during S_CLEAR: no swap; swap_pending is retained and serviced at the next frame_tick in S_ARB.
- swap_req during S_CLEAR is latched into swap_pending.
- Write issued in the cycle the swap is applied uses the old bank. Because gnt is 0 in the event cycle, no requester write straddles the swap.
- Reset asserted mid-clear aborts the sweep immediately; wr_bank returns to 0.
- Address width: no range checking; requester addresses pass through unmodified.

Decomposition:
- Package vram_sched_pkg: state enum {S_ARB, S_CLEAR}; localparams VRAM_DEPTH=20480, VRAM_AW=19, PIX_W=12.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], accept, gnt[1:0], rr_last register).
- Top holds the swap/clear FSM and output registers.

Test Plan:
- Reset then r0_req=1 with addr 5, data 12'hF00 for 1 cycle -> r0_gnt=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=12'hF00, wr_bank=0.
- r0_req and r1_req held high for 4 cycles -> grants alternate r0,r1,r0,r1; wr_en=1 on 4 consecutive cycles.
- swap_req pulse, frame_tick 10 cycles later, clear_en=0 -> gnt=0 on tick cycle; next cycle wr_bank=1, swap_ack=1, frame_count=1.
- Swap with clear_en=1, clear_color=12'h00F -> 20480 writes, addr 0..20479, data 12'h00F; clearing high exactly 20480 cycles; r1_req is ignored until done, then granted.
- frame_tick during clear with swap_req latched -> no toggle; toggle occurs at the first frame_tick after clearing=0.
- reset pulled low at clear address 100 -> all outputs return to reset values asynchronously; after release, r0 has first priority and wr_bank=0.
